count_seq_checker: RTL and testbench

Downstream consumer of the 8-bit up-counter output. Samples the counter's `count` every enabled cycle, predicts the next value (+1 mod 2^WIDTH), and flags any deviation. It checks the post-reset seed value, counts mismatches and wrap-arounds, and raises `done` after N_TV checked samples. Serves as the self-check stage in the counter lab harness.

---
 rtl/count_seq_checker_pkg.sv | 17 +
 rtl/count_seq_checker_if.sv | 29 ++
 rtl/count_seq_checker_sat_counter.sv | 30 +++
 rtl/count_seq_checker.sv | 110 +++++++++++
 tb/tb_count_seq_checker.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/count_seq_checker_pkg.sv
// Shared counter-lab definitions so the up-counter and its checker agree on
// widths, seed and test-vector count.
package count_seq_checker_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCheck,
        StDone
    } state_e;

    localparam int unsigned DefWidth    = 8;
    localparam int unsigned DefSeed     = 4;
    localparam int unsigned DefNTv      = 256;
    localparam int unsigned DefLogNTv   = 8;
    localparam int unsigned DefErrWidth = 8;

endpackage

// File: rtl/count_seq_checker_if.sv
// Sample bus between the lab harness (master) and the sequence checker (slave).
interface count_seq_checker_if
    import count_seq_checker_pkg::*;
#(
    parameter int unsigned Width    = DefWidth,
    parameter int unsigned LogNTv   = DefLogNTv,
    parameter int unsigned ErrWidth = DefErrWidth
) ();

    logic                en;
    logic [Width-1:0]    count;
    logic                mismatch;
    logic                seed_err;
    logic [ErrWidth-1:0] err_cnt;
    logic [ErrWidth-1:0] wrap_cnt;
    logic [LogNTv:0]     checked;
    logic                done;

    modport master (
        output en, count,
        input  mismatch, seed_err, err_cnt, wrap_cnt, checked, done
    );

    modport slave (
        input  en, count,
        output mismatch, seed_err, err_cnt, wrap_cnt, checked, done
    );

endinterface

// File: rtl/count_seq_checker_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of rolling over.
module count_seq_checker_sat_counter #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (inc_i && (q_q != '1)) begin
            q_d = q_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/count_seq_checker.sv
// Checks that an up-counter stream increments by one per enabled sample,
// seed-checks the first sample and stops after NTv samples.
module count_seq_checker
    import count_seq_checker_pkg::*;
#(
    parameter int unsigned Width    = DefWidth,
    parameter int unsigned Seed     = DefSeed,
    parameter int unsigned NTv      = DefNTv,
    parameter int unsigned LogNTv   = DefLogNTv,
    parameter int unsigned ErrWidth = DefErrWidth
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    count_seq_checker_if.slave  bus
);

    localparam logic [Width-1:0]  SeedVal = Width'(Seed);
    localparam logic [LogNTv:0]   NTvCnt  = (LogNTv + 1)'(NTv);
    localparam logic [LogNTv:0]   OneCnt  = (LogNTv + 1)'(1);

    state_e           state_q;
    logic [Width-1:0] expected_q;
    logic             resync_q;
    logic             mismatch_q;
    logic             seed_err_q;
    logic [LogNTv:0]  checked_q;
    logic             done_q;

    logic             compare_en;
    logic             err_inc;
    logic             wrap_inc;
    logic [LogNTv:0]  checked_nxt;

    // The first sample after an enable gap only re-seeds the prediction.
    assign compare_en  = (state_q == StCheck) && bus.en && !resync_q;
    assign err_inc     = compare_en && (bus.count != expected_q);
    assign wrap_inc    = compare_en && (bus.count == expected_q) && (expected_q == '0);
    assign checked_nxt = checked_q + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            expected_q <= SeedVal;
            resync_q   <= 1'b0;
            mismatch_q <= 1'b0;
            seed_err_q <= 1'b0;
            checked_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            mismatch_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.en) begin
                        seed_err_q <= (bus.count != SeedVal);
                        expected_q <= bus.count + 1'b1;
                        checked_q  <= OneCnt;
                        if (NTvCnt == OneCnt) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StCheck;
                        end
                    end
                end
                StCheck: begin
                    if (bus.en) begin
                        // Re-align to the observed value so one jump is one error.
                        mismatch_q <= err_inc;
                        expected_q <= bus.count + 1'b1;
                        resync_q   <= 1'b0;
                        checked_q  <= checked_nxt;
                        if (checked_nxt == NTvCnt) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        resync_q <= 1'b1;
                    end
                end
                StDone: begin
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    count_seq_checker_sat_counter #(
        .Width (ErrWidth)
    ) u_err_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (err_inc),
        .q_o    (bus.err_cnt)
    );

    count_seq_checker_sat_counter #(
        .Width (ErrWidth)
    ) u_wrap_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (wrap_inc),
        .q_o    (bus.wrap_cnt)
    );

    assign bus.mismatch = mismatch_q;
    assign bus.seed_err = seed_err_q;
    assign bus.checked  = checked_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// Bench for count_seq_checker: directed scenarios plus a randomized stream,
// all compared against a sample-level model of the checking rules.
module tb_count_seq_checker;
    import count_seq_checker_pkg::*;

    localparam int W    = 8;
    localparam int SEED = 4;
    localparam int NTV  = 256;
    localparam int LOGN = 8;
    localparam int EW   = 8;
    localparam int EMAX = 255;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    count_seq_checker_if #(.Width(W), .LogNTv(LOGN), .ErrWidth(EW)) bus ();
    count_seq_checker_if #(.Width(W), .LogNTv(9), .ErrWidth(EW)) bus2 ();

    count_seq_checker #(
        .Width(W), .Seed(SEED), .NTv(NTV), .LogNTv(LOGN), .ErrWidth(EW)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    count_seq_checker #(
        .Width(W), .Seed(SEED), .NTv(512), .LogNTv(9), .ErrWidth(EW)
    ) dut_sat (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus2)
    );

    int total = 0;
    int bad   = 0;

    // Sample-level model: what the checker should report after each sample.
    bit m_started, m_finished, m_gap, m_seed_err, m_mismatch;
    int m_exp, m_checked, m_err, m_wrap;

    function automatic void model_clear();
        m_started = 0; m_finished = 0; m_gap = 0; m_seed_err = 0; m_mismatch = 0;
        m_exp = SEED; m_checked = 0; m_err = 0; m_wrap = 0;
    endfunction

    function automatic void model_sample(input bit en, input int cnt);
        m_mismatch = 0;
        if (m_finished) return;
        if (!en) begin
            if (m_started) m_gap = 1;
            return;
        end
        if (!m_started) begin
            m_started  = 1;
            m_seed_err = (cnt != SEED);
        end else if (!m_gap) begin
            if (cnt != m_exp) begin
                m_mismatch = 1;
                m_err = (m_err < EMAX) ? m_err + 1 : EMAX;
            end else if (m_exp == 0) begin
                m_wrap = (m_wrap < EMAX) ? m_wrap + 1 : EMAX;
            end
        end
        m_gap     = 0;
        m_exp     = (cnt + 1) % 256;
        m_checked = m_checked + 1;
        if (m_checked == NTV) m_finished = 1;
    endfunction

    function automatic logic [27:0] dut_vec();
        return {bus.mismatch, bus.seed_err, bus.err_cnt, bus.wrap_cnt, bus.checked, bus.done};
    endfunction

    function automatic logic [27:0] model_vec();
        logic [7:0] e, w;
        logic [8:0] c;
        e = m_err[7:0];
        w = m_wrap[7:0];
        c = m_checked[8:0];
        return {m_mismatch, m_seed_err, e, w, c, m_finished};
    endfunction

    // Drive one sample between edges; outputs are read 1 ns after the edge.
    task automatic step(input bit en, input int cnt);
        @(negedge clk);
        bus.en    = en;
        bus.count = cnt[7:0];
        @(posedge clk);
        model_sample(en, cnt);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        bus.en   = 1'b0;
        bus2.en  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        bus.en    = 1'b1;
        bus.count = 8'd4;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (dut_vec() !== 28'h0) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d got=%h want=0", i, dut_vec());
            end
        end
        @(negedge clk);
        bus.en = 1'b0;
        rst_n  = 1'b1;
        model_clear();
        step(1'b0, 4);
        total++;
        if (dut_vec() !== 28'h0) begin
            bad++;
            $display("FAIL reset_release got=%h want=0", dut_vec());
        end
    endtask

    task automatic test_full_run();
        bit saw_mm = 0;
        do_reset();
        for (int i = 0; i < NTV; i++) begin
            step(1'b1, (SEED + i) % 256);
            if (bus.mismatch) saw_mm = 1;
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++;
                $display("FAIL full_run i=%0d got=%h want=%h", i, dut_vec(), model_vec());
            end
        end
        total++;
        if ({bus.done, bus.checked, bus.err_cnt, bus.wrap_cnt, bus.seed_err, saw_mm} !==
            {1'b1, 9'd256, 8'd0, 8'd1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL full_run_end done=%b checked=%0d err=%0d wrap=%0d seed=%b mm=%b",
                     bus.done, bus.checked, bus.err_cnt, bus.wrap_cnt, bus.seed_err, saw_mm);
        end
        // DONE ignores further samples, even bad ones.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 100 + 7 * i);
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++;
                $display("FAIL done_hold i=%0d got=%h want=%h", i, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_seed_err();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 7 + i);
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++;
                $display("FAIL seed_err i=%0d got=%h want=%h", i, dut_vec(), model_vec());
            end
        end
        total++;
        if ({bus.seed_err, bus.err_cnt} !== {1'b1, 8'd0}) begin
            bad++;
            $display("FAIL seed_err_end seed=%b err=%0d want seed=1 err=0",
                     bus.seed_err, bus.err_cnt);
        end
    endtask

    task automatic test_glitch();
        int seq [6] = '{4, 5, 6, 9, 10, 11};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, seq[i]);
            total++;
            if (bus.mismatch !== (i == 3)) begin
                bad++;
                $display("FAIL glitch_pulse i=%0d got=%b want=%b", i, bus.mismatch, i == 3);
            end
        end
        total++;
        if (bus.err_cnt !== 8'd1) begin
            bad++;
            $display("FAIL glitch_err_cnt got=%0d want=1", bus.err_cnt);
        end
    endtask

    task automatic test_gap();
        do_reset();
        for (int i = 4; i <= 20; i++) step(1'b1, i);
        for (int i = 0; i < 5; i++) step(1'b0, 21 + 2 * i);
        total++;
        if ({bus.checked, bus.mismatch} !== {9'd17, 1'b0}) begin
            bad++;
            $display("FAIL gap_hold checked=%0d mm=%b want 17/0", bus.checked, bus.mismatch);
        end
        step(1'b1, 30);
        step(1'b1, 31);
        total++;
        if ({bus.checked, bus.err_cnt, bus.mismatch} !== {9'd19, 8'd0, 1'b0}) begin
            bad++;
            $display("FAIL gap_resume checked=%0d err=%0d mm=%b want 19/0/0",
                     bus.checked, bus.err_cnt, bus.mismatch);
        end
        total++;
        if (dut_vec() !== model_vec()) begin
            bad++;
            $display("FAIL gap_model got=%h want=%h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_saturation();
        do_reset();
        @(negedge clk);
        bus2.en    = 1'b1;
        bus2.count = 8'd4;
        @(posedge clk);
        #1;
        // Constant count mismatches the +1 prediction on every sample.
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk);
            #1;
            total++;
            if ({bus2.err_cnt, bus2.mismatch} !== {8'((i < EMAX) ? i : EMAX), 1'b1}) begin
                bad++;
                $display("FAIL sat i=%0d err=%0d mm=%b want err=%0d mm=1",
                         i, bus2.err_cnt, bus2.mismatch, (i < EMAX) ? i : EMAX);
            end
        end
        @(negedge clk);
        bus2.en = 1'b0;
        total++;
        if ({bus2.checked, bus2.wrap_cnt, bus2.done} !== {10'd301, 8'd0, 1'b0}) begin
            bad++;
            $display("FAIL sat_end checked=%0d wrap=%0d done=%b want 301/0/0",
                     bus2.checked, bus2.wrap_cnt, bus2.done);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 4 + i + ((i >= 10) ? 50 : 0) + ((i >= 25) ? 50 : 0));
        end
        total++;
        if ({bus.checked, bus.err_cnt} !== {9'd40, 8'd2}) begin
            bad++;
            $display("FAIL pre_reset checked=%0d err=%0d want 40/2", bus.checked, bus.err_cnt);
        end
        @(negedge clk);
        bus.en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (dut_vec() !== 28'h0) begin
            bad++;
            $display("FAIL async_reset got=%h want=0", dut_vec());
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        step(1'b1, 9);
        total++;
        if ({bus.seed_err, bus.checked, bus.err_cnt} !== {1'b1, 9'd1, 8'd0}) begin
            bad++;
            $display("FAIL reseed seed=%b checked=%0d err=%0d want 1/1/0",
                     bus.seed_err, bus.checked, bus.err_cnt);
        end
    endtask

    task automatic test_random();
        int cnt;
        bit en;
        do_reset();
        cnt = 240 + $urandom_range(0, 15);
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) cnt = $urandom_range(0, 255);
            step(en, cnt);
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++;
                $display("FAIL random i=%0d en=%b cnt=%0d got=%h want=%h",
                         i, en, cnt, dut_vec(), model_vec());
            end
            cnt = en ? (cnt + 1) % 256 : (cnt + $urandom_range(0, 3)) % 256;
        end
    endtask

    initial begin
        bus.en     = 1'b0;
        bus.count  = '0;
        bus2.en    = 1'b0;
        bus2.count = '0;
        model_clear();
        test_reset();
        test_full_run();
        test_seed_err();
        test_glitch();
        test_gap();
        test_saturation();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
